// File: rtl/regfile_mp_pkg.sv
// Shared types and constants for the multi-port register file.
// Holds default geometry and the clear/ready state encodings.
package regfile_mp_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_NUM_RD   = 2;
  localparam int RF_NUM_WR   = 2;

  localparam logic [0:0] RF_CLEAR = 1'b0;
  localparam logic [0:0] RF_READY = 1'b1;

  typedef logic [RF_ADDR_W-1:0] reg_addr_t;
  typedef logic [RF_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_mp_bypass.sv
// Per-read-port priority mux: bypasses same-cycle writes and predicts next busy bit.
// Purely combinational; output is zero when disabled, not enabled or reading x0.
module regfile_bypass
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_WR = RF_NUM_WR
) (
  input  logic                     en,
  input  logic                     re,
  input  logic [ADDR_W-1:0]        raddr,
  input  logic [DATA_W-1:0]        reg_rdata,
  input  logic                     reg_busy,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic                     set_busy,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic                     flush,
  output logic [DATA_W-1:0]        rdata,
  output logic                     rbusy
);

  always_comb begin
    rdata = '0;
    rbusy = 1'b0;
    if (en && re && (raddr != '0)) begin
      rdata = reg_rdata;
      rbusy = reg_busy;
      // Ascending scan so the highest-index matching port takes the last word.
      for (int i = 0; i < NUM_WR; i++) begin
        if (we[i] && (waddr[i*ADDR_W +: ADDR_W] == raddr)) begin
          rdata = wdata[i*DATA_W +: DATA_W];
          rbusy = 1'b0;
        end
      end
      if (set_busy && (set_addr == raddr)) begin
        rbusy = 1'b1;
      end
      if (flush) begin
        rbusy = 1'b0;
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with busy scoreboard and post-reset zeroing sequencer.
// Writes land at the edge; reads bypass same-cycle writes; ready rises NUM_REGS cycles after reset.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = RF_NUM_RD,
  parameter int NUM_WR   = RF_NUM_WR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     set_busy,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic                     flush,
  output logic                     ready
);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              active;

  assign ready  = (state_q == RF_READY);
  assign active = ready && !rst;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == RF_CLEAR) begin
      cnt_d = cnt_q + ADDR_W'(1);
      if (cnt_q == ADDR_W'(NUM_REGS - 1)) begin
        state_d = RF_READY;
      end
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (!rst && (state_q == RF_CLEAR)) begin
      regs_d[cnt_q] = '0;
    end else if (active) begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (we[i] && (waddr[i*ADDR_W +: ADDR_W] != '0)) begin
          regs_d[waddr[i*ADDR_W +: ADDR_W]] = wdata[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Precedence: write clears, then a new producer sets, then flush wipes all.
  always_comb begin
    busy_d = busy_q;
    if (active) begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (we[i]) begin
          busy_d[waddr[i*ADDR_W +: ADDR_W]] = 1'b0;
        end
      end
      if (set_busy && (set_addr != '0)) begin
        busy_d[set_addr] = 1'b1;
      end
      if (flush) begin
        busy_d = '0;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RF_CLEAR;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = raddr[j*ADDR_W +: ADDR_W];

    regfile_bypass #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NUM_WR (NUM_WR)
    ) u_bypass (
      .en        (active),
      .re        (re[j]),
      .raddr     (ra),
      .reg_rdata (regs_q[ra]),
      .reg_busy  (busy_q[ra]),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .set_busy  (set_busy),
      .set_addr  (set_addr),
      .flush     (flush),
      .rdata     (rdata[j*DATA_W +: DATA_W]),
      .rbusy     (rbusy[j])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: clear sequence, write/read, bypass priority, scoreboard, flush, reset.
module tb_regfile_mp;

  logic        clk;
  logic        rst;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [1:0]  re;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic        set_busy;
  logic [4:0]  set_addr;
  logic        flush;
  logic        ready;

  int checks = 0;
  int errors = 0;
  int n;

  regfile_mp dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .re       (re),
    .raddr    (raddr),
    .rdata    (rdata),
    .rbusy    (rbusy),
    .set_busy (set_busy),
    .set_addr (set_addr),
    .flush    (flush),
    .ready    (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; we = '0; waddr = '0; wdata = '0; re = 2'b11; raddr = '0;
    set_busy = 1'b0; set_addr = '0; flush = 1'b0;
    repeat (3) tick();
    raddr = {5'd31, 5'd5};
    #1;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_rdata0", rdata[31:0], 32'd0);
    check("rst_rbusy", 32'(rbusy), 32'd0);

    // Release reset and try to write x5 during the clear sequence.
    rst = 1'b0; we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'd0, 32'hDEADBEEF};
    n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
      if (!ready && n == 10) begin
        #1;
        check("clear_rdata_mid", rdata[31:0], 32'd0);
      end
    end
    we = '0;
    #1;
    check("clear_cycles", 32'(n), 32'd32);
    check("clear_x5", rdata[31:0], 32'd0);
    check("clear_x31", rdata[63:32], 32'd0);

    tick();
    we = 2'b01; waddr = {5'd0, 5'd7}; wdata = {32'd0, 32'h12345678};
    tick();
    we = '0; raddr = {5'd7, 5'd7};
    #1;
    check("wr_x7_p0", rdata[31:0], 32'h12345678);
    check("wr_x7_p1", rdata[63:32], 32'h12345678);

    we = 2'b10; waddr = {5'd0, 5'd0}; wdata = {32'hFFFFFFFF, 32'd0}; raddr = {5'd0, 5'd0};
    #1;
    check("x0_bypass", rdata[31:0], 32'd0);
    tick();
    we = '0;
    #1;
    check("x0_after", rdata[63:32], 32'd0);

    we = 2'b11; waddr = {5'd3, 5'd3}; wdata = {32'h2, 32'h1}; raddr = {5'd3, 5'd3};
    #1;
    check("prio_bypass", rdata[31:0], 32'h2);
    tick();
    we = '0;
    #1;
    check("prio_stored", rdata[63:32], 32'h2);

    re = 2'b10; raddr = {5'd3, 5'd7};
    #1;
    check("re_off_p0", rdata[31:0], 32'd0);
    check("re_on_p1", rdata[63:32], 32'h2);
    re = 2'b11;

    set_busy = 1'b1; set_addr = 5'd9; raddr = {5'd9, 5'd9};
    #1;
    check("busy_set_same", 32'(rbusy[0]), 32'd1);
    tick();
    set_busy = 1'b0;
    #1;
    check("busy_set_held", 32'(rbusy[1]), 32'd1);
    tick();
    we = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'd0, 32'h55};
    set_busy = 1'b1; set_addr = 5'd9;
    #1;
    check("busy_set_wins_same", 32'(rbusy[0]), 32'd1);
    tick();
    we = '0; set_busy = 1'b0;
    #1;
    check("busy_set_wins_after", 32'(rbusy[0]), 32'd1);
    check("busy_wr_data", rdata[31:0], 32'h55);
    tick();
    we = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'd0, 32'h66};
    #1;
    check("busy_wr_clear_same", 32'(rbusy[0]), 32'd0);
    tick();
    we = '0;
    #1;
    check("busy_wr_clear_after", 32'(rbusy), 32'd0);
    set_busy = 1'b1; set_addr = 5'd0; raddr = {5'd0, 5'd0};
    tick();
    set_busy = 1'b0;
    #1;
    check("busy_x0", 32'(rbusy), 32'd0);

    set_busy = 1'b1; set_addr = 5'd4;
    tick();
    set_addr = 5'd10;
    tick();
    set_addr = 5'd20;
    tick();
    set_busy = 1'b0; raddr = {5'd10, 5'd4};
    #1;
    check("flush_pre_4_10", 32'(rbusy), 32'd3);
    raddr = {5'd20, 5'd4};
    #1;
    check("flush_pre_20", 32'(rbusy[1]), 32'd1);
    flush = 1'b1; set_busy = 1'b1; set_addr = 5'd11; raddr = {5'd11, 5'd4};
    #1;
    check("flush_same", 32'(rbusy), 32'd0);
    tick();
    flush = 1'b0; set_busy = 1'b0;
    #1;
    check("flush_11_4", 32'(rbusy), 32'd0);
    raddr = {5'd20, 5'd10};
    #1;
    check("flush_20_10", 32'(rbusy), 32'd0);

    set_busy = 1'b1; set_addr = 5'd7;
    tick();
    set_busy = 1'b0; raddr = {5'd7, 5'd7};
    #1;
    check("mid_busy_x7", 32'(rbusy), 32'd3);
    check("mid_data_x7", rdata[31:0], 32'h12345678);
    rst = 1'b1;
    #1;
    check("mid_rst_rdata", rdata[63:32], 32'd0);
    check("mid_rst_rbusy", 32'(rbusy), 32'd0);
    tick();
    check("mid_ready_drop", 32'(ready), 32'd0);
    rst = 1'b0;
    #1;
    check("mid_clear_rbusy", 32'(rbusy), 32'd0);
    n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
    end
    #1;
    check("mid_clear_cycles", 32'(n), 32'd32);
    check("mid_x7_zero", rdata[31:0], 32'd0);
    check("mid_x7_notbusy", 32'(rbusy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file. Successor to the single-write / dual-read register file.
- Adds configurable read/write port counts and data width.
- Adds a per-register busy scoreboard for issue-time hazard tracking.
- Adds a post-reset clear sequencer that zeroes all registers before signalling ready.
- Sits between the decode/issue stage (reads, busy set) and the writeback stage (writes, busy clear).

Parameters:
- DATA_W, 32, register width in bits
- NUM_REGS, 32, number of architectural registers; must be a power of 2; x0 hardwired to zero
- ADDR_W, 5, register address width; equals log2(NUM_REGS)
- NUM_RD, 2, number of read ports
- NUM_WR, 2, number of write ports

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- we  in  NUM_WR  per-port write enable
- waddr  in  NUM_WR*ADDR_W  write addresses, flattened; port i at [i*ADDR_W +: ADDR_W]
- wdata  in  NUM_WR*DATA_W  write data, flattened likewise
- re  in  NUM_RD  per-port read enable
- raddr  in  NUM_RD*ADDR_W  read addresses, flattened
- rdata  out  NUM_RD*DATA_W  read data, combinational
- rbusy  out  NUM_RD  busy bit of each read address, combinational
- set_busy  in  1  mark register set_addr as having a pending producer
- set_addr  in  ADDR_W  register to mark busy
- flush  in  1  clear all busy bits (pipeline flush)
- ready  out  1  high once the clear sequence has completed

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset:
  - On any clk edge with rst=1: FSM goes to CLEAR, clear counter goes to 0, ready goes to 0, all busy bits go to 0.
  - While rst=1, all rdata and rbusy outputs read 0.
  - Reset asserted mid-CLEAR or mid-operation restarts the clear sequence from register 0.
- FSM:
  - CLEAR: each cycle write 0 to regs[cnt] and increment cnt. When cnt == NUM_REGS-1, the final register is written and the FSM moves to READY on the next edge. This takes exactly NUM_REGS cycles after rst deasserts.
  - READY: ready=1. Normal operation. The FSM leaves READY only on rst.
- During CLEAR:
  - we, set_busy and flush are ignored.
  - rdata and rbusy read 0.
- Writes (READY only):
  - Port i writes wdata_i to regs[waddr_i] on the clk edge when we_i=1 and waddr_i != 0.
  - A write also clears the busy bit of waddr_i.
  - If two write ports target the same address in one cycle, the highest-index port wins for both the data and the busy clear.
- Reads (combinational, every port independent):
  - rdata_j is 0 if rst, !ready, !re_j, or raddr_j == 0.
  - Otherwise, if any write port has we_i=1 and waddr_i == raddr_j: bypass wdata_i, highest-index matching port wins.
  - Otherwise: regs[raddr_j].
  - rbusy_j follows the same zero conditions. Otherwise it equals the next-state busy bit: a same-cycle write to the address clears it, a same-cycle set_busy to the address sets it.
- Busy scoreboard:
  - set_busy with set_addr != 0 sets busy[set_addr] at the edge. set_busy with set_addr == 0 is a no-op; x0 is never busy.
  - Set and write-clear on the same address in the same cycle: set wins (a new producer was issued).
  - flush=1 clears every busy bit at the edge and overrides set_busy in the same cycle. Writes in that cycle still update data.
- Width rules: addresses are unsigned; no range checking is needed because NUM_REGS is a power of 2.
- Register storage has no reset other than the clear sequence.
- Simulation-only $display of each write (port, address, data) is retained.

Decomposition:
- Shared header defines.v: RegNum, RegAddrBus and RegBus generalised to the parameters above. Also holds FSM state encodings RF_CLEAR and RF_READY.
- One natural sub-module: regfile_bypass. This is the per-read-port combinational priority mux over the write ports (data and busy next-state), instantiated NUM_RD times by generate.

Test Plan:
- Clear sequence: hold rst 3 cycles with regs pre-filled via force, then release. ready must rise exactly 32 cycles later; reading x5 and x31 must return 0; a we issued during CLEAR to x5=0xDEADBEEF must have no effect.
- Write then read: write x7=0x12345678 via port 0; on the next cycle read x7 on ports 0 and 1, and both must return 0x12345678. Writing x0=0xFFFFFFFF must leave x0 reading 0.
- Bypass and priority: in the same cycle, port 0 writes x3=0x1 and port 1 writes x3=0x2, while x3 is read. rdata must be 0x2 that cycle, and x3 must hold 0x2 afterwards.
- Scoreboard: set_busy x9, then rbusy for x9 must be 1. In a later cycle, write x9 and set_busy x9 simultaneously; x9 must stay busy. A write alone must then clear it. set_busy x0 must keep rbusy 0.
- Flush: set x4, x10 and x20 busy; assert flush together with set_busy x11. All rbusy must be 0 afterwards, including x11.
- Reset mid-operation: assert rst while READY with x7 busy. ready must drop the next edge, x7 rbusy must be 0, and after release x7 must read 0 once ready returns after 32 cycles.
